// File: rtl/bit_collector_pkg.sv
//------------------------------------------------------------------------------
// Module   : bit_collector_pkg
// Purpose  : Shared FSM state type and default width for the bit collector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bit_collector_pkg;

  localparam int c_DEFAULT_W = 8;

  // FILL: frame being accumulated; HOLD: complete frame presented to consumer.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : bit_collector_pkg

`default_nettype wire

// File: rtl/bit_decoder.sv
//------------------------------------------------------------------------------
// Module   : bit_decoder
// Purpose  : Turns a bit index into an enable-gated one-hot write strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_decoder #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic [SW-1:0] i_sel,
  input  logic          i_en,
  output logic [W-1:0]  o_strobe
);

  // Indices at or above W match no lane, so they yield an all-zero strobe.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_strobe[i] = i_en && (i_sel == SW'(i));
  end

endmodule : bit_decoder

`default_nettype wire

// File: rtl/bit_collector.sv
//------------------------------------------------------------------------------
// Module   : bit_collector
// Purpose  : Assembles W individually addressed bits into a frame and holds
//            the completed frame until the consumer accepts it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_collector
  import bit_collector_pkg::*;
#(
  parameter int W  = c_DEFAULT_W,
  parameter int SW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_in,
  input  logic [SW-1:0] sel,
  input  logic          wr_en,
  input  logic          clear,
  input  logic          out_ready,
  output logic [W-1:0]  data_out,
  output logic [W-1:0]  fill_mask,
  output logic          out_valid,
  output logic          wr_drop,
  output logic          overwrite
);

  state_e       r_state;
  logic [W-1:0] r_data;
  logic [W-1:0] r_mask;
  logic         r_valid;
  logic         r_drop;
  logic         r_ovw;

  logic         w_in_hold;
  logic         w_accept;
  logic         w_wr_apply;
  logic         w_drop;
  logic         w_ovw;
  logic         w_full;
  logic [W-1:0] w_strobe;
  logic [W-1:0] w_mask_base;
  logic [W-1:0] w_mask_next;
  logic [W-1:0] w_data_next;
  state_e       w_state_next;

  assign w_in_hold  = (r_state == HOLD);
  assign w_accept   = w_in_hold && out_ready && !clear;
  // In HOLD a write only lands when the held frame is accepted in the same cycle.
  assign w_wr_apply = wr_en && !clear && (!w_in_hold || out_ready);
  assign w_drop     = wr_en && !clear && w_in_hold && !out_ready;

  bit_decoder #(
    .W  (W),
    .SW (SW)
  ) u_bit_decoder (
    .i_sel    (sel),
    .i_en     (w_wr_apply),
    .o_strobe (w_strobe)
  );

  assign w_mask_base = w_accept ? '0 : r_mask;
  assign w_mask_next = clear ? '0 : (w_mask_base | w_strobe);
  assign w_data_next = (r_data & ~w_strobe) | ({W{bit_in}} & w_strobe);
  assign w_ovw       = |(w_mask_base & w_strobe);
  assign w_full      = &w_mask_next;

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = FILL;
    end else begin
      case (r_state)
        FILL:    w_state_next = w_full ? HOLD : FILL;
        HOLD:    if (out_ready) w_state_next = w_full ? HOLD : FILL;
        default: w_state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_data  <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      r_ovw   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_mask  <= w_mask_next;
      r_valid <= (w_state_next == HOLD);
      r_drop  <= w_drop;
      r_ovw   <= w_ovw;
    end
  end

  assign data_out  = r_data;
  assign fill_mask = r_mask;
  assign out_valid = r_valid;
  assign wr_drop   = r_drop;
  assign overwrite = r_ovw;

endmodule : bit_collector

`default_nettype wire

// File: tb/tb_bit_collector.sv
//------------------------------------------------------------------------------
// Module   : tb_bit_collector
// Purpose  : Directed and randomized self-checking bench for bit_collector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bit_collector;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic [2:0] sel;
  logic       wr_en;
  logic       clear;
  logic       out_ready;
  logic [7:0] data_out;
  logic [7:0] fill_mask;
  logic       out_valid;
  logic       wr_drop;
  logic       overwrite;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: frame contents, written flags, frame-complete flag.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  logic       m_hold;
  logic       e_drop;
  logic       e_ovw;

  bit_collector #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .sel       (sel),
    .wr_en     (wr_en),
    .clear     (clear),
    .out_ready (out_ready),
    .data_out  (data_out),
    .fill_mask (fill_mask),
    .out_valid (out_valid),
    .wr_drop   (wr_drop),
    .overwrite (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_mask = '0;
    m_hold = 1'b0;
    e_drop = 1'b0;
    e_ovw  = 1'b0;
  endtask

  task automatic model_step(input logic b, input int s, input logic we,
                            input logic clr, input logic rdy);
    e_drop = 1'b0;
    e_ovw  = 1'b0;
    if (clr) begin
      m_mask = '0;
      m_hold = 1'b0;
    end else if (m_hold && !rdy) begin
      e_drop = we;
    end else begin
      if (m_hold) begin
        m_mask = '0;
        m_hold = 1'b0;
      end
      if (we) begin
        e_ovw     = m_mask[s];
        m_data[s] = b;
        m_mask[s] = 1'b1;
      end
      if ($countones(m_mask) == 8) m_hold = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"},  {24'd0, data_out},  {24'd0, m_data});
    chk({tag, "_mask"},  {24'd0, fill_mask}, {24'd0, m_mask});
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_hold});
    chk({tag, "_drop"},  {31'd0, wr_drop},   {31'd0, e_drop});
    chk({tag, "_ovw"},   {31'd0, overwrite}, {31'd0, e_ovw});
  endtask

  task automatic cycle(input string tag, input logic b, input int s, input logic we,
                       input logic clr, input logic rdy);
    bit_in    = b;
    sel       = 3'(s);
    wr_en     = we;
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(b, s, we, clr, rdy);
    check_model(tag);
    wr_en     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  {24'd0, data_out},  32'd0);
    chk({tag, "_mask"},  {24'd0, fill_mask}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drop"},  {31'd0, wr_drop},   32'd0);
    chk({tag, "_ovw"},   {31'd0, overwrite}, 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; bit_in = 1'b0; sel = '0; wr_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill sel 0..7 with 1,0,1,1,0,0,1,0 -> 8'h4D
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      cycle("fill", pat[i], i, 1'b1, 1'b0, 1'b0);
      if (i < 7) chk("fill_not_yet_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("fill_valid", {31'd0, out_valid}, 32'd1);
    chk("fill_data", {24'd0, data_out}, 32'h4D);

    // Back-pressure: write dropped while held
    cycle("bp_drop", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("bp_drop_pulse", {31'd0, wr_drop}, 32'd1);
    chk("bp_data_kept", {24'd0, data_out}, 32'h4D);
    cycle("bp_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_drop_once", {31'd0, wr_drop}, 32'd0);
    cycle("bp_accept", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("bp_valid_low", {31'd0, out_valid}, 32'd0);
    chk("bp_mask_zero", {24'd0, fill_mask}, 32'd0);

    // Overwrite of bit 3
    cycle("ow_first", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    chk("ow_no_pulse", {31'd0, overwrite}, 32'd0);
    cycle("ow_second", 1'b0, 3, 1'b1, 1'b0, 1'b0);
    chk("ow_pulse", {31'd0, overwrite}, 32'd1);
    chk("ow_bit3", {31'd0, data_out[3]}, 32'd0);
    chk("ow_mask", {24'd0, fill_mask}, 32'h08);
    cycle("ow_after", 1'b1, 6, 1'b1, 1'b0, 1'b0);
    chk("ow_pulse_once", {31'd0, overwrite}, 32'd0);

    // Complete frame, then accept and write in the same cycle
    for (int i = 0; i < 8; i++) cycle("fill2", 1'b0, i, 1'b1, 1'b0, 1'b0);
    chk("fill2_valid", {31'd0, out_valid}, 32'd1);
    cycle("acc_wr", 1'b1, 5, 1'b1, 1'b0, 1'b1);
    chk("acc_wr_valid", {31'd0, out_valid}, 32'd0);
    chk("acc_wr_mask", {24'd0, fill_mask}, 32'h20);
    chk("acc_wr_bit5", {31'd0, data_out[5]}, 32'd1);
    chk("acc_wr_nodrop", {31'd0, wr_drop}, 32'd0);

    // Clear mid-frame after 4 writes
    for (int i = 0; i < 3; i++) cycle("pre_clr", 1'b1, i, 1'b1, 1'b0, 1'b0);
    cycle("clr", 1'b1, 6, 1'b1, 1'b1, 1'b0);
    chk("clr_mask", {24'd0, fill_mask}, 32'd0);
    chk("clr_nodrop", {31'd0, wr_drop}, 32'd0);
    chk("clr_data_kept", {24'd0, data_out}, 32'h27);

    // Async reset after 6 writes, asserted between edges
    for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b1, i, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 2, 1'b1, 1'b0, 1'b0);
    chk("post_rst_mask", {24'd0, fill_mask}, 32'h04);

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      cycle("rand",
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bit_collector

`default_nettype wire

// File: doc/bit_collector.md
BIT_COLLECTOR -- requirements
Module: bit_collector

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the number of assembled bits; SW = $clog2(W).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port bit_in, input, 1, the serial data bit to deposit.
REQ-005 The block SHALL have port sel, input, SW, the destination bit index for bit_in.
REQ-006 The block SHALL have port wr_en, input, 1, which qualifies bit_in and sel for one cycle.
REQ-007 The block SHALL have port clear, input, 1, a synchronous abort of the current frame.
REQ-008 The block SHALL have port out_ready, input, 1, the consumer acceptance of a completed byte.
REQ-009 The block SHALL have port data_out, output, W, the registered assembled bits.
REQ-010 The block SHALL have port fill_mask, output, W, the registered per-bit "written this frame" flags.
REQ-011 The block SHALL have port out_valid, output, 1, asserted while a complete frame is held.
REQ-012 The block SHALL have port wr_drop, output, 1, a one-cycle registered pulse marking a rejected write.
REQ-013 The block SHALL have port overwrite, output, 1, a one-cycle registered pulse marking a write to an already-filled bit.

Function
REQ-014 The block SHALL use a two-state FSM: FILL (accumulating) and HOLD (complete frame presented).
REQ-015 In FILL with wr_en=1: data_out[sel] SHALL take bit_in and fill_mask[sel] SHALL be set at the next edge; all other bits SHALL be unchanged.
REQ-016 The write latency SHALL be 1 cycle: a write sampled at edge N SHALL be visible on data_out and fill_mask after edge N.
REQ-017 In FILL, a write to a bit whose fill_mask is already 1 SHALL overwrite data_out[sel] and SHALL pulse overwrite for 1 cycle.
REQ-018 When the write at edge N makes fill_mask all ones, state SHALL become HOLD and out_valid SHALL be 1 after edge N.
REQ-019 In HOLD, data_out SHALL be stable; wr_en without out_ready SHALL be ignored and SHALL pulse wr_drop.
REQ-020 In HOLD with out_ready=1: fill_mask SHALL clear, state SHALL become FILL and out_valid SHALL drop at the next edge.
REQ-021 In HOLD with out_ready=1 and wr_en=1 in the same cycle, the write SHALL be applied to the new frame, leaving fill_mask = one-hot(sel), and SHALL NOT pulse wr_drop.
REQ-022 When out_ready and wr_en together complete a frame and the new frame has W=1, the block SHALL return to HOLD.
REQ-023 clear=1 SHALL take priority over every other input: fill_mask SHALL go to 0, state SHALL go to FILL and out_valid SHALL go to 0; data_out SHALL be retained; wr_en in that cycle SHALL be discarded without a wr_drop pulse.
REQ-024 out_ready in FILL SHALL have no effect.
REQ-025 data_out bits not yet written in the current frame SHALL retain their previous-frame values; consumers SHALL rely only on data_out when out_valid=1.

Reset
REQ-026 While rst_n=0, the block SHALL hold state=FILL, data_out=0, fill_mask=0, out_valid=0, wr_drop=0 and overwrite=0, independent of clk.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the frame; the first write after rst_n rises SHALL start a fresh frame.

Structure
REQ-028 A shared package bit_collector_pkg SHALL hold the FSM state enum typedef (FILL, HOLD) and the default width constant (8).
REQ-029 One sub-module, bit_decoder, SHALL convert sel to a W-bit one-hot write strobe gated by its enable; all other logic SHALL stay in bit_collector.

Verification
REQ-030 Reset and fill: with rst_n low, outputs SHALL read 0; writing sel 0..7 with bits 1,0,1,1,0,0,1,0 (one per cycle) SHALL give out_valid=1 exactly one cycle after the 8th write and data_out=8'h4D.
REQ-031 Overwrite: writing sel=3 with bit 1, then sel=3 with bit 0, SHALL pulse overwrite once; data_out[3]=0 and fill_mask=8'h08.
REQ-032 Back-pressure: in HOLD with out_ready=0, a write with sel=0 and bit 0 SHALL pulse wr_drop and leave data_out unchanged; raising out_ready SHALL drop out_valid next cycle and give fill_mask=0.
REQ-033 Simultaneous accept and write: in HOLD, out_ready=1 with wr_en=1, sel=5, bit 1 SHALL give FILL, fill_mask=8'h20 and data_out[5]=1, with no wr_drop.
REQ-034 Clear and reset mid-frame: after 4 writes, clear=1 with wr_en=1 SHALL give fill_mask=0 with no wr_drop; after 6 writes, asserting rst_n low between edges SHALL zero all outputs immediately.
